beam_counter_gen: RTL and testbench

Parametrised beam-position generator for the Alice-class display chip family. Runs from the 28 MHz master clock with an internal colour-clock (CCK) enable, and counts horizontal and vertical beam position. Generates HSYNC, VSYNC and CSYNC, plus line and frame strobes, and latches light-pen position. Adds programmable totals (variable-beam mode), NTSC long/short-line alternation, interlace long/short frame, and parametrised counter widths.

---
 rtl/beam_pkg.sv | 25 ++
 rtl/cck_div.sv | 26 ++
 rtl/beam_counter_gen.sv | 198 +++++++++++++++++++
 tb/tb_beam_counter_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/beam_pkg.sv
// Shared constants and types for the beam-position generator.
package beam_pkg;

  // Counter widths
  localparam int unsigned DefHctrW    = 9;
  localparam int unsigned DefVctrW    = 11;

  // Last counts of the short line / short frame in each standard
  localparam int unsigned DefPalHtot  = 226;
  localparam int unsigned DefNtscHtot = 226;
  localparam int unsigned DefPalVtot  = 311;
  localparam int unsigned DefNtscVtot = 261;

  // Sync windows: start is the first asserted count, stop the first deasserted count
  localparam int unsigned DefHsStart  = 18;
  localparam int unsigned DefHsStop   = 35;
  localparam int unsigned DefVsStart  = 2;
  localparam int unsigned DefVsStop   = 5;

  typedef enum logic {
    MODE_NTSC = 1'b0,
    MODE_PAL  = 1'b1
  } mode_e;

endpackage

// File: rtl/cck_div.sv
// Divide-by-8 of the master clock producing the colour-clock enable.
module cck_div (
  input  logic clk_i,
  input  logic rst_ni,
  output logic cck_en_o
);

  logic [2:0] div_q, div_d;

  // Free-running count; 7 wraps to 0 by overflow.
  always_comb begin
    div_d = div_q + 3'd1;
  end

  // Divider state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign cck_en_o = (div_q == 3'd7);

endmodule

// File: rtl/beam_counter_gen.sv
// Beam-position generator: CCK-rate H/V counters, syncs, line/frame strobes and light-pen latch.
module beam_counter_gen
  import beam_pkg::*;
#(
  parameter int unsigned HCTR_W    = DefHctrW,
  parameter int unsigned VCTR_W    = DefVctrW,
  parameter int unsigned PAL_HTOT  = DefPalHtot,
  parameter int unsigned NTSC_HTOT = DefNtscHtot,
  parameter int unsigned PAL_VTOT  = DefPalVtot,
  parameter int unsigned NTSC_VTOT = DefNtscVtot,
  parameter int unsigned HS_START  = DefHsStart,
  parameter int unsigned HS_STOP   = DefHsStop,
  parameter int unsigned VS_START  = DefVsStart,
  parameter int unsigned VS_STOP   = DefVsStop
) (
  input  logic              PAD_C28M,
  input  logic              PAD_NRST,
  input  logic              nntsc_pal,
  input  logic              interlace,
  input  logic              varbeam,
  input  logic [HCTR_W-1:0] htotal,
  input  logic [VCTR_W-1:0] vtotal,
  input  logic              nlp,
  output logic              cck_en,
  output logic [HCTR_W-1:0] hctr,
  output logic [VCTR_W-1:0] vctr,
  output logic              lol,
  output logic              lof,
  output logic              line_stb,
  output logic              frame_stb,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              csync_n,
  output logic [HCTR_W-1:0] lp_h,
  output logic [VCTR_W-1:0] lp_v,
  output logic              lp_valid
);

  mode_e             mode_q, mode_d;
  logic [HCTR_W-1:0] hctr_q, hctr_d, htot;
  logic [VCTR_W-1:0] vctr_q, vctr_d, vtot;
  logic [HCTR_W:0]   hlast;
  logic [VCTR_W:0]   vlast;
  logic              lol_q, lol_d, lof_q, lof_d;
  logic              line_wrap, frame_wrap, lol_allowed;
  logic              line_stb_q, frame_stb_q;
  logic              hs_n, vs_n, hsync_q, vsync_q, csync_q;
  logic              lp_meta_q, lp_sync_q, lp_prev_q, pen_fall;
  logic [HCTR_W-1:0] lp_h_q, lp_h_d;
  logic [VCTR_W-1:0] lp_v_q, lp_v_d;
  logic              lp_valid_q, lp_valid_d;

  cck_div u_cck_div (
    .clk_i    (PAD_C28M),
    .rst_ni   (PAD_NRST),
    .cck_en_o (cck_en)
  );

  // Select the active totals: programmable in variable-beam mode, else per latched standard.
  always_comb begin
    if (varbeam) begin
      htot = htotal;
      vtot = vtotal;
    end else if (mode_q == MODE_PAL) begin
      htot = HCTR_W'(PAL_HTOT);
      vtot = VCTR_W'(PAL_VTOT);
    end else begin
      htot = HCTR_W'(NTSC_HTOT);
      vtot = VCTR_W'(NTSC_VTOT);
    end
  end

  // One extra bit so HTOT+lol / VTOT+lof cannot alias onto a small count.
  assign hlast = {1'b0, htot} + {{HCTR_W{1'b0}}, lol_q};
  assign vlast = {1'b0, vtot} + {{VCTR_W{1'b0}}, lof_q};

  // A total set below the current count is never matched; all-ones is the fallback wrap point.
  assign line_wrap   = cck_en && (({1'b0, hctr_q} == hlast) || (&hctr_q));
  assign frame_wrap  = line_wrap && (({1'b0, vctr_q} == vlast) || (&vctr_q));
  assign lol_allowed = (mode_q == MODE_NTSC) && !varbeam;

  // Counter, line/frame length and mode next-state; everything advances only on cck_en.
  always_comb begin
    hctr_d = hctr_q;
    vctr_d = vctr_q;
    lol_d  = lol_q;
    lof_d  = lof_q;
    mode_d = mode_q;
    if (cck_en) begin
      hctr_d = line_wrap ? '0 : hctr_q + HCTR_W'(1);
      if (!lol_allowed) begin
        lol_d = 1'b0;
      end else if (line_wrap) begin
        lol_d = ~lol_q;
      end
      if (line_wrap) begin
        vctr_d = frame_wrap ? '0 : vctr_q + VCTR_W'(1);
      end
      if (frame_wrap) begin
        lof_d  = interlace ? ~lof_q : 1'b1;
        mode_d = nntsc_pal ? MODE_PAL : MODE_NTSC;
      end
    end
  end

  // Beam state and strobe registers; strobes coincide with the counters reading 0.
  always_ff @(posedge PAD_C28M or negedge PAD_NRST) begin
    if (!PAD_NRST) begin
      hctr_q      <= '0;
      vctr_q      <= '0;
      lol_q       <= 1'b0;
      lof_q       <= 1'b1;
      mode_q      <= MODE_PAL;
      line_stb_q  <= 1'b0;
      frame_stb_q <= 1'b0;
    end else begin
      hctr_q      <= hctr_d;
      vctr_q      <= vctr_d;
      lol_q       <= lol_d;
      lof_q       <= lof_d;
      mode_q      <= mode_d;
      line_stb_q  <= line_wrap;
      frame_stb_q <= frame_wrap;
    end
  end

  assign hs_n = !((hctr_q >= HCTR_W'(HS_START)) && (hctr_q < HCTR_W'(HS_STOP)));
  assign vs_n = !((vctr_q >= VCTR_W'(VS_START)) && (vctr_q < VCTR_W'(VS_STOP)));

  // Syncs are decoded from the current counters and registered, so they trail by one clock.
  always_ff @(posedge PAD_C28M or negedge PAD_NRST) begin
    if (!PAD_NRST) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      csync_q <= 1'b1;
    end else begin
      hsync_q <= hs_n;
      vsync_q <= vs_n;
      csync_q <= hs_n & vs_n;
    end
  end

  // Two-flop synchroniser plus a history flop for falling-edge detect; idles high.
  always_ff @(posedge PAD_C28M or negedge PAD_NRST) begin
    if (!PAD_NRST) begin
      lp_meta_q <= 1'b1;
      lp_sync_q <= 1'b1;
      lp_prev_q <= 1'b1;
    end else begin
      lp_meta_q <= nlp;
      lp_sync_q <= lp_meta_q;
      lp_prev_q <= lp_sync_q;
    end
  end

  assign pen_fall = lp_prev_q & ~lp_sync_q;

  // First pen edge per frame is captured; the frame-wrap clear beats a simultaneous edge.
  always_comb begin
    lp_h_d     = lp_h_q;
    lp_v_d     = lp_v_q;
    lp_valid_d = lp_valid_q;
    if (frame_wrap) begin
      lp_valid_d = 1'b0;
    end else if (pen_fall && !lp_valid_q) begin
      lp_h_d     = hctr_q;
      lp_v_d     = vctr_q;
      lp_valid_d = 1'b1;
    end
  end

  // Pen latch registers; position holds across the frame-wrap clear.
  always_ff @(posedge PAD_C28M or negedge PAD_NRST) begin
    if (!PAD_NRST) begin
      lp_h_q     <= '0;
      lp_v_q     <= '0;
      lp_valid_q <= 1'b0;
    end else begin
      lp_h_q     <= lp_h_d;
      lp_v_q     <= lp_v_d;
      lp_valid_q <= lp_valid_d;
    end
  end

  assign hctr      = hctr_q;
  assign vctr      = vctr_q;
  assign lol       = lol_q;
  assign lof       = lof_q;
  assign line_stb  = line_stb_q;
  assign frame_stb = frame_stb_q;
  assign hsync_n   = hsync_q;
  assign vsync_n   = vsync_q;
  assign csync_n   = csync_q;
  assign lp_h      = lp_h_q;
  assign lp_v      = lp_v_q;
  assign lp_valid  = lp_valid_q;

endmodule

// File: tb/tb_beam_counter_gen.sv
// Self-checking bench for beam_counter_gen: mode table, pen sequences, random run vs model.
module tb_beam_counter_gen;

  logic        clk = 1'b0;
  logic        PAD_NRST;
  logic        nntsc_pal, interlace, varbeam, nlp;
  logic [8:0]  htotal;
  logic [10:0] vtotal;
  logic        cck_en, lol, lof, line_stb, frame_stb, hsync_n, vsync_n, csync_n, lp_valid;
  logic [8:0]  hctr, lp_h;
  logic [10:0] vctr, lp_v;

  beam_counter_gen dut (
    .PAD_C28M  (clk),
    .PAD_NRST  (PAD_NRST),
    .nntsc_pal (nntsc_pal),
    .interlace (interlace),
    .varbeam   (varbeam),
    .htotal    (htotal),
    .vtotal    (vtotal),
    .nlp       (nlp),
    .cck_en    (cck_en),
    .hctr      (hctr),
    .vctr      (vctr),
    .lol       (lol),
    .lof       (lof),
    .line_stb  (line_stb),
    .frame_stb (frame_stb),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .csync_n   (csync_n),
    .lp_h      (lp_h),
    .lp_v      (lp_v),
    .lp_valid  (lp_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: beam position as plain integers, advanced once per master clock.
  int m_div, m_hc, m_vc, m_lph, m_lpv;
  bit m_lol, m_lof, m_pal, m_line, m_frame, m_hs, m_vs, m_cs, m_lpvalid;
  bit m_hist[3];  // nlp as seen by the synchroniser: [0] newest

  task automatic model_reset();
    m_div = 0; m_hc = 0; m_vc = 0; m_lph = 0; m_lpv = 0;
    m_lol = 1'b0; m_lof = 1'b1; m_pal = 1'b1; m_line = 1'b0; m_frame = 1'b0;
    m_hs = 1'b1; m_vs = 1'b1; m_cs = 1'b1; m_lpvalid = 1'b0;
    m_hist[0] = 1'b1; m_hist[1] = 1'b1; m_hist[2] = 1'b1;
  endtask

  task automatic model_step();
    int htot, vtot;
    bit cck, lw, fw, fall;
    cck  = (m_div == 7);
    fall = m_hist[2] && !m_hist[1];
    m_hs = !(m_hc >= 18 && m_hc < 35);
    m_vs = !(m_vc >= 2 && m_vc < 5);
    m_cs = m_hs && m_vs;
    htot = varbeam ? int'(htotal) : 226;
    vtot = varbeam ? int'(vtotal) : (m_pal ? 311 : 261);
    lw = cck && ((m_hc == htot + int'(m_lol)) || (m_hc == 511));
    fw = lw && ((m_vc == vtot + int'(m_lof)) || (m_vc == 2047));
    if (fw) m_lpvalid = 1'b0;
    else if (fall && !m_lpvalid) begin
      m_lph = m_hc; m_lpv = m_vc; m_lpvalid = 1'b1;
    end
    if (cck) begin
      m_lol = (!m_pal && !varbeam) ? (lw ? !m_lol : m_lol) : 1'b0;
      m_hc  = lw ? 0 : m_hc + 1;
      if (lw) m_vc = fw ? 0 : m_vc + 1;
      if (fw) begin
        m_lof = interlace ? !m_lof : 1'b1;
        m_pal = nntsc_pal;
      end
    end
    m_line = lw;
    m_frame = fw;
    m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = nlp;
    m_div = (m_div + 1) % 8;
  endtask

  function automatic logic [63:0] dut_vec();
    return {15'd0, cck_en, hctr, vctr, lol, lof, line_stb, frame_stb,
            hsync_n, vsync_n, csync_n, lp_h, lp_v, lp_valid};
  endfunction

  function automatic logic [63:0] model_vec();
    return {15'd0, (m_div == 7), 9'(m_hc), 11'(m_vc), m_lol, m_lof, m_line, m_frame,
            m_hs, m_vs, m_cs, 9'(m_lph), 11'(m_lpv), m_lpvalid};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic reset_dut(input bit chk);
    PAD_NRST = 1'b0;
    #1;
    model_reset();
    if (chk) check("reset_state", dut_vec(), model_vec());
    @(posedge clk);
    #1;
    PAD_NRST = 1'b1;
  endtask

  task automatic wait_line(input int budget, output int clocks, output int hs_low);
    clocks = 0; hs_low = 0;
    forever begin
      step();
      clocks++;
      if (!hsync_n) hs_low++;
      if (line_stb || clocks >= budget) break;
    end
    if (!line_stb) begin
      n_vec++; n_bad++;
      $display("FAIL line_timeout: no line_stb within %0d clocks", budget);
    end
  endtask

  task automatic wait_frame(input int budget, output int lines);
    int clocks = 0;
    lines = 0;
    forever begin
      step();
      clocks++;
      if (line_stb) lines++;
      if (frame_stb || clocks >= budget) break;
    end
    if (!frame_stb) begin
      n_vec++; n_bad++;
      $display("FAIL frame_timeout: no frame_stb within %0d clocks", budget);
    end
  endtask

  typedef struct {
    bit pal; bit intl; bit vb; int htot; int vtot;
    int line_a; int line_b; int frame_a; int frame_b; int hs_low;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int p1, p2, hs1, hs2, f1, f2, cap_h;

    // Line periods in clocks, frame lengths in lines (0 = frame not measured).
    tbl[0] = '{pal:1, intl:0, vb:0, htot:0,  vtot:0, line_a:1816, line_b:1816,
               frame_a:0,  frame_b:0,  hs_low:136};
    tbl[1] = '{pal:0, intl:0, vb:0, htot:0,  vtot:0, line_a:1824, line_b:1816,
               frame_a:0,  frame_b:0,  hs_low:136};
    tbl[2] = '{pal:1, intl:0, vb:1, htot:99, vtot:9, line_a:800,  line_b:800,
               frame_a:11, frame_b:11, hs_low:136};
    tbl[3] = '{pal:1, intl:1, vb:1, htot:29, vtot:9, line_a:240,  line_b:240,
               frame_a:10, frame_b:11, hs_low:96};
    tbl[4] = '{pal:0, intl:0, vb:1, htot:49, vtot:4, line_a:400,  line_b:400,
               frame_a:6,  frame_b:6,  hs_low:136};
    tbl[5] = '{pal:1, intl:1, vb:1, htot:20, vtot:3, line_a:168,  line_b:168,
               frame_a:4,  frame_b:5,  hs_low:24};

    PAD_NRST = 1'b1; nntsc_pal = 1'b1; interlace = 1'b0; varbeam = 1'b0;
    htotal = 9'd0; vtotal = 11'd0; nlp = 1'b1;
    #2;
    reset_dut(1'b1);

    for (int e = 0; e < 6; e++) begin
      reset_dut(1'b0);
      // Short variable-beam frame so the requested standard gets latched at a frame wrap.
      varbeam = 1'b1; htotal = 9'd9; vtotal = 11'd1; interlace = 1'b0;
      nntsc_pal = tbl[e].pal;
      wait_frame(2000, f1);
      varbeam = tbl[e].vb; htotal = 9'(tbl[e].htot); vtotal = 11'(tbl[e].vtot);
      interlace = tbl[e].intl;
      wait_line(5000, p1, hs1);
      wait_line(5000, p1, hs1);
      wait_line(5000, p2, hs2);
      check($sformatf("e%0d_line_a", e), 64'(p1), 64'(tbl[e].line_a));
      check($sformatf("e%0d_line_b", e), 64'(p2), 64'(tbl[e].line_b));
      check($sformatf("e%0d_hsync_low", e), 64'(hs1), 64'(tbl[e].hs_low));
      if (tbl[e].frame_a != 0) begin
        wait_frame(20000, f1);
        wait_frame(20000, f1);
        wait_frame(20000, f2);
        check($sformatf("e%0d_frame_a", e), 64'(f1), 64'(tbl[e].frame_a));
        check($sformatf("e%0d_frame_b", e), 64'(f2), 64'(tbl[e].frame_b));
      end
    end

    // Reset asserted mid-line clears the counters without waiting for a clock.
    varbeam = 1'b1; htotal = 9'd99; vtotal = 11'd9;
    for (int i = 0; i < 5000 && !(vctr == 11'd3 && hctr == 9'd40); i++) step();
    check("midline_reach", 64'(vctr == 11'd3 && hctr == 9'd40), 64'd1);
    reset_dut(1'b1);

    // Light pen: capture, ignore a second pulse, clear at frame wrap.
    varbeam = 1'b1; htotal = 9'd49; vtotal = 11'd9; interlace = 1'b0; nntsc_pal = 1'b1;
    nlp = 1'b1;
    for (int i = 0; i < 6000 && !(hctr == 9'd20 && vctr == 11'd5); i++) step();
    check("pen_reach", 64'(hctr == 9'd20 && vctr == 11'd5), 64'd1);
    nlp = 1'b0;
    repeat (6) step();
    cap_h = int'(lp_h);
    check("pen_valid", 64'(lp_valid), 64'd1);
    check("pen_h", 64'(lp_h == 9'd20 || lp_h == 9'd21), 64'd1);
    check("pen_v", 64'(lp_v), 64'd5);
    nlp = 1'b1;
    for (int i = 0; i < 6000 && vctr != 11'd8; i++) step();
    nlp = 1'b0;
    repeat (20) step();
    nlp = 1'b1;
    repeat (5) step();
    check("pen2_h", 64'(lp_h), 64'(cap_h));
    check("pen2_v", 64'(lp_v), 64'd5);
    check("pen2_valid", 64'(lp_valid), 64'd1);
    for (int i = 0; i < 6000 && !frame_stb; i++) step();
    check("pen_clr_valid", 64'(lp_valid), 64'd0);
    check("pen_clr_hold_v", 64'(lp_v), 64'd5);

    // Pen edge detected on the exact frame-wrap clock: the clear must win.
    for (int i = 0; i < 6000 && !(hctr == 9'd49 && vctr == 11'd10); i++) step();
    repeat (5) step();
    nlp = 1'b0;
    repeat (3) step();
    check("wrap_align", 64'(frame_stb), 64'd1);
    check("pen_on_wrap", 64'(lp_valid), 64'd0);
    repeat (10) step();
    check("pen_on_wrap_late", 64'(lp_valid), 64'd0);
    nlp = 1'b1;

    // Randomised run compared every clock against the model.
    reset_dut(1'b0);
    for (int s = 0; s < 10; s++) begin
      varbeam   = ($urandom_range(0, 3) != 0);
      interlace = 1'($urandom_range(0, 1));
      nntsc_pal = 1'($urandom_range(0, 1));
      htotal    = 9'($urandom_range(20, 60));
      vtotal    = 11'(m_vc + int'($urandom_range(1, 6)));
      for (int c = 0; c < 1000; c++) begin
        step();
        check("cycle", dut_vec(), model_vec());
        if ($urandom_range(0, 149) == 0) nlp = ~nlp;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
